hilo_move_sequencer: RTL and testbench
======================================

// Module: hilo_move_sequencer
// PURPOSE
//  Hardwired control sequencer driving CPU_datapath control inputs for fetch plus the four HI/LO move
//  instructions (mfhi, mflo, mthi, mtlo). Replaces hand-timed T0..T3 control sequences with a reset-safe FSM.
//  Supports configurable memory-read wait states, a run/done handshake and illegal-opcode trapping.
//  Sits beside CPU_datapath; opcode is fed back from the datapath's IR decode.
// PARAMETERS
//  OPW       5         opcode width
//  MEM_WAIT  0         extra RAM read wait cycles between FETCH0 and FETCH1 (0..15)
//  CNT_W     16        retired-instruction counter width
//  OP_MFHI   5'b10111  mfhi opcode
//  OP_MFLO   5'b11000  mflo opcode
//  OP_MTHI   5'b10101  mthi opcode
//  OP_MTLO   5'b10110  mtlo opcode
// PORTS
//  clk       in   1      system clock, rising edge
//  rst       in   1      asynchronous, active-high reset
//  run       in   1      level: 1 = keep executing instructions
//  opcode    in   OPW    IR[31:27] from datapath
//  PCout,MARin,IncPC,RAMrd,Read,MDRin,MDRout,IRin   out 1 each  fetch controls
//  Gra,R_enableIn,Rout                               out 1 each  register-file select/enables
//  HIin,LOin,HIout,LOout                             out 1 each  HI/LO enables
//  busy      out  1      1 in any state except IDLE/FAULT
//  done      out  1      one-cycle pulse on instruction retire
//  illegal   out  1      sticky; 1 in FAULT
//  retired   out  CNT_W  count of retired instructions
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE, wait cnt=0, retired=0; every output 0.
//  - States: IDLE, F0, FWAIT, F1, F2, EXEC, FAULT. Control outputs are Moore decodes of state (glitch-free regs).
//  - IDLE: all ctrl 0. run=1 -> F0.
//  - F0: PCout, MARin, IncPC, RAMrd = 1. MEM_WAIT=0 -> F1, else -> FWAIT with cnt=MEM_WAIT-1.
//  - FWAIT: RAMrd=1; cnt==0 -> F1 else cnt--.
//  - F1: RAMrd, Read, MDRin = 1 -> F2.
//  - F2: MDRout, IRin = 1 -> EXEC (opcode valid from EXEC onward).
//  - EXEC (one cycle), Gra=1 always:
//      mfhi: HIout, R_enableIn | mflo: LOout, R_enableIn | mthi: Rout, HIin | mtlo: Rout, LOin.
//    Legal: done=1, retired+1 (wraps 2^CNT_W-1 -> 0); run=1 -> F0 (back-to-back), run=0 -> IDLE.
//    Other opcode: no enables asserted (Gra too), no done, no increment -> FAULT.
//  - FAULT: illegal=1, all ctrl 0, ignores run; exits only via rst.
//  - run dropping mid-instruction does not abort; instruction completes, then IDLE.
//  - Never more than one bus driver (PCout/MDRout/HIout/LOout/Rout) per cycle; at most one of HIin/LOin.
//  - Latency: IDLE->done = 4+MEM_WAIT cycles after run sampled; steady throughput one instr per 4+MEM_WAIT.
// STRUCTURE
//  - Shared package cpu_ctrl_pkg: state enum/localparams, opcode constants (OP_MFHI..OP_MTLO), OPW.
//  - One sub-module natural: mem_wait_counter (load/decrement/zero flag, 4 bits); rest inline.
//  - Outputs decoded from registered state in one combinational block; next-state in another.
// TESTING
//  1 rst pulse mid-F1 with MEM_WAIT=0 -> next cycle state=IDLE, all ctrl 0, retired=0, busy=0.
//  2 LO=15, R2 target, opcode=11000, run=1 one instr -> EXEC: LOout=R_enableIn=Gra=1; R2=15; done 1 cycle; retired=1.
//  3 MEM_WAIT=2, opcode mfhi, HI=32'hDEADBEEF -> RAMrd held 4 cycles (F0,W,W,F1); done at cycle 6; Rdest=DEADBEEF.
//  4 run held, mthi then mtlo from R1=8 -> F0 immediately after EXEC; HI=8, LO=8; retired=2; never both HIin,LOin.
//  5 opcode=5'b00000 -> no enables in EXEC, illegal=1 next cycle, busy=0, stays FAULT with run=1; rst clears.
//  6 CNT_W=2, 5 back-to-back mflo -> retired 1,2,3,0,1; run deasserted in F2 of 5th -> completes, IDLE.

Source files
------------

// File: rtl/hilo_move_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// hilo_move_sequencer_pkg
// Shared definitions for the HI/LO move control sequencer:
//   - state_t  : sequencer state encoding (also exposed on the debug port)
//   - ctrl_t   : bundle of datapath control enables driven by the sequencer
//   - opcode width and the four HI/LO move opcodes
// -----------------------------------------------------------------------------
package hilo_move_sequencer_pkg;

  localparam int OPW = 5;

  localparam logic [OPW-1:0] OP_MFHI = 5'b10111;
  localparam logic [OPW-1:0] OP_MFLO = 5'b11000;
  localparam logic [OPW-1:0] OP_MTHI = 5'b10101;
  localparam logic [OPW-1:0] OP_MTLO = 5'b10110;

  // Width of the memory wait-state counter; MEM_WAIT is limited to 0..15.
  localparam int WAIT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_F0    = 3'd1,
    ST_FWAIT = 3'd2,
    ST_F1    = 3'd3,
    ST_F2    = 3'd4,
    ST_EXEC  = 3'd5,
    ST_FAULT = 3'd6
  } state_t;

  typedef struct packed {
    logic pc_out;
    logic mar_in;
    logic inc_pc;
    logic ram_rd;
    logic read;
    logic mdr_in;
    logic mdr_out;
    logic ir_in;
    logic gra;
    logic r_enable_in;
    logic r_out;
    logic hi_in;
    logic lo_in;
    logic hi_out;
    logic lo_out;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

endpackage

// File: rtl/hilo_move_sequencer_mem_wait_counter.sv
// -----------------------------------------------------------------------------
// hilo_move_sequencer_mem_wait_counter
// Small down-counter that times the RAM read wait states between FETCH0 and
// FETCH1. Loaded on leaving F0, decremented once per wait cycle, and reports
// when it has reached zero.
// Ports:
//   clk      in  1       system clock, rising edge
//   rst      in  1       asynchronous, active-high reset (count -> 0)
//   load     in  1       load count with load_val (has priority over dec)
//   load_val in  WAIT_W  value to load
//   dec      in  1       decrement by one (holds at zero)
//   zero     out 1       count == 0
// -----------------------------------------------------------------------------
module hilo_move_sequencer_mem_wait_counter
  import hilo_move_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [WAIT_W-1:0] load_val,
  input  logic              dec,
  output logic              zero
);

  logic [WAIT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/hilo_move_sequencer.sv
// -----------------------------------------------------------------------------
// hilo_move_sequencer
// Hardwired control sequencer for CPU_datapath: instruction fetch plus the
// four HI/LO move instructions (mfhi, mflo, mthi, mtlo). Optional RAM read
// wait states, a level run input, a one-cycle done pulse on retire, a retired
// instruction counter and a sticky illegal-opcode trap.
//
// Handshake: run is a level. It is sampled in IDLE to start a fetch and in
// EXEC to decide between an immediate back-to-back fetch (run=1) and IDLE
// (run=0). A started instruction always completes; done pulses for exactly
// the EXEC cycle of every legal instruction.
//
// Ports:
//   clk, rst                         clock, async active-high reset
//   run                              level, keep executing instructions
//   opcode[OPW]                      IR[31:27] from the datapath (valid in EXEC)
//   PCout..IRin                      fetch controls
//   Gra, R_enableIn, Rout            register-file select/enables
//   HIin, LOin, HIout, LOout         HI/LO enables
//   busy                             1 except in IDLE/FAULT
//   done                             one-cycle retire pulse
//   illegal                          1 while in FAULT (sticky until rst)
//   retired[CNT_W]                   retired instruction count (wraps)
//   state_dbg[3]                     current state encoding, for observation
// -----------------------------------------------------------------------------
module hilo_move_sequencer
  import hilo_move_sequencer_pkg::*;
#(
  parameter int             MEM_WAIT = 0,
  parameter int             CNT_W    = 16,
  parameter logic [OPW-1:0] OP_MFHI_P = OP_MFHI,
  parameter logic [OPW-1:0] OP_MFLO_P = OP_MFLO,
  parameter logic [OPW-1:0] OP_MTHI_P = OP_MTHI,
  parameter logic [OPW-1:0] OP_MTLO_P = OP_MTLO
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [OPW-1:0]   opcode,
  output logic             PCout,
  output logic             MARin,
  output logic             IncPC,
  output logic             RAMrd,
  output logic             Read,
  output logic             MDRin,
  output logic             MDRout,
  output logic             IRin,
  output logic             Gra,
  output logic             R_enableIn,
  output logic             Rout,
  output logic             HIin,
  output logic             LOin,
  output logic             HIout,
  output logic             LOout,
  output logic             busy,
  output logic             done,
  output logic             illegal,
  output logic [CNT_W-1:0] retired,
  output logic [2:0]       state_dbg
);

  localparam bit HAS_WAIT = (MEM_WAIT > 0);
  // F0 itself is not a wait cycle, so the counter starts one below MEM_WAIT.
  localparam logic [WAIT_W-1:0] WAIT_LOAD =
    HAS_WAIT ? WAIT_W'(MEM_WAIT - 1) : '0;

  state_t state;
  state_t state_nxt;
  ctrl_t  ctrl;

  logic cnt_load;
  logic cnt_dec;
  logic cnt_zero;

  logic is_mfhi;
  logic is_mflo;
  logic is_mthi;
  logic is_mtlo;
  logic legal;

  assign is_mfhi = (opcode == OP_MFHI_P);
  assign is_mflo = (opcode == OP_MFLO_P);
  assign is_mthi = (opcode == OP_MTHI_P);
  assign is_mtlo = (opcode == OP_MTLO_P);
  assign legal   = is_mfhi | is_mflo | is_mthi | is_mtlo;

  hilo_move_sequencer_mem_wait_counter u_wait (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (WAIT_LOAD),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and wait-counter control.
  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (run) state_nxt = ST_F0;
      end
      ST_F0: begin
        if (HAS_WAIT) begin
          state_nxt = ST_FWAIT;
          cnt_load  = 1'b1;
        end else begin
          state_nxt = ST_F1;
        end
      end
      ST_FWAIT: begin
        if (cnt_zero) state_nxt = ST_F1;
        else          cnt_dec   = 1'b1;
      end
      ST_F1:   state_nxt = ST_F2;
      ST_F2:   state_nxt = ST_EXEC;
      ST_EXEC: begin
        if (!legal)   state_nxt = ST_FAULT;
        else if (run) state_nxt = ST_F0;
        else          state_nxt = ST_IDLE;
      end
      ST_FAULT: state_nxt = ST_FAULT;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Output decode from the registered state. Only EXEC looks at opcode,
  // which the datapath holds stable in IR for the whole EXEC cycle. Each
  // state enables at most one bus driver and at most one of HIin/LOin.
  always_comb begin
    ctrl = CTRL_NONE;
    done = 1'b0;
    case (state)
      ST_F0: begin
        ctrl.pc_out = 1'b1;
        ctrl.mar_in = 1'b1;
        ctrl.inc_pc = 1'b1;
        ctrl.ram_rd = 1'b1;
      end
      ST_FWAIT: ctrl.ram_rd = 1'b1;
      ST_F1: begin
        ctrl.ram_rd = 1'b1;
        ctrl.read   = 1'b1;
        ctrl.mdr_in = 1'b1;
      end
      ST_F2: begin
        ctrl.mdr_out = 1'b1;
        ctrl.ir_in   = 1'b1;
      end
      ST_EXEC: begin
        // An illegal opcode leaves every enable low, including Gra.
        ctrl.gra = legal;
        done     = legal;
        if (is_mfhi) begin
          ctrl.hi_out      = 1'b1;
          ctrl.r_enable_in = 1'b1;
        end else if (is_mflo) begin
          ctrl.lo_out      = 1'b1;
          ctrl.r_enable_in = 1'b1;
        end else if (is_mthi) begin
          ctrl.r_out = 1'b1;
          ctrl.hi_in = 1'b1;
        end else if (is_mtlo) begin
          ctrl.r_out = 1'b1;
          ctrl.lo_in = 1'b1;
        end
      end
      default: ctrl = CTRL_NONE;
    endcase
  end

  // Retired counter; wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired <= '0;
    end else if ((state == ST_EXEC) && legal) begin
      retired <= retired + 1'b1;
    end
  end

  assign busy      = (state != ST_IDLE) && (state != ST_FAULT);
  assign illegal   = (state == ST_FAULT);
  assign state_dbg = state;

  assign PCout      = ctrl.pc_out;
  assign MARin      = ctrl.mar_in;
  assign IncPC      = ctrl.inc_pc;
  assign RAMrd      = ctrl.ram_rd;
  assign Read       = ctrl.read;
  assign MDRin      = ctrl.mdr_in;
  assign MDRout     = ctrl.mdr_out;
  assign IRin       = ctrl.ir_in;
  assign Gra        = ctrl.gra;
  assign R_enableIn = ctrl.r_enable_in;
  assign Rout       = ctrl.r_out;
  assign HIin       = ctrl.hi_in;
  assign LOin       = ctrl.lo_in;
  assign HIout      = ctrl.hi_out;
  assign LOout      = ctrl.lo_out;

endmodule

// File: tb/tb_hilo_move_sequencer.sv
// -----------------------------------------------------------------------------
// tb_hilo_move_sequencer
// Directed bench for hilo_move_sequencer. Two instances share clk/rst:
//   dut_a : MEM_WAIT=0, CNT_W=2  (reset, mflo, mthi/mtlo, illegal, wrap)
//   dut_b : MEM_WAIT=2, CNT_W=16 (wait-state timing with mfhi)
// A tiny HI/LO/register model per instance reacts to the control enables so
// data movement can be checked. Control vector bit order:
//   {PCout,MARin,IncPC,RAMrd,Read,MDRin,MDRout,IRin,
//    Gra,R_enableIn,Rout,HIin,LOin,HIout,LOout}
// -----------------------------------------------------------------------------
module tb_hilo_move_sequencer;

  localparam logic [14:0] C_NONE = 15'h0000;
  localparam logic [14:0] C_F0   = 15'h7800;
  localparam logic [14:0] C_WAIT = 15'h0800;
  localparam logic [14:0] C_F1   = 15'h0E00;
  localparam logic [14:0] C_F2   = 15'h0180;
  localparam logic [14:0] C_MFHI = 15'h0062;
  localparam logic [14:0] C_MFLO = 15'h0061;
  localparam logic [14:0] C_MTHI = 15'h0058;
  localparam logic [14:0] C_MTLO = 15'h0054;

  localparam logic [2:0] S_IDLE = 3'd0, S_F0 = 3'd1, S_FWAIT = 3'd2,
                         S_F1 = 3'd3, S_F2 = 3'd4, S_EXEC = 3'd5, S_FAULT = 3'd6;

  localparam logic [4:0] OPC_MFHI = 5'b10111, OPC_MFLO = 5'b11000,
                         OPC_MTHI = 5'b10101, OPC_MTLO = 5'b10110;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- dut_a signals ----------------
  logic       run_a = 1'b0;
  logic [4:0] opcode_a = '0;
  logic pc_out_a, mar_in_a, inc_pc_a, ram_rd_a, read_a, mdr_in_a, mdr_out_a, ir_in_a;
  logic gra_a, r_en_a, r_out_a, hi_in_a, lo_in_a, hi_out_a, lo_out_a;
  logic busy_a, done_a, illegal_a;
  logic [1:0] retired_a;
  logic [2:0] state_a;
  logic [14:0] ctrl_a;
  assign ctrl_a = {pc_out_a, mar_in_a, inc_pc_a, ram_rd_a, read_a, mdr_in_a, mdr_out_a,
                   ir_in_a, gra_a, r_en_a, r_out_a, hi_in_a, lo_in_a, hi_out_a, lo_out_a};

  // ---------------- dut_b signals ----------------
  logic       run_b = 1'b0;
  logic [4:0] opcode_b = '0;
  logic pc_out_b, mar_in_b, inc_pc_b, ram_rd_b, read_b, mdr_in_b, mdr_out_b, ir_in_b;
  logic gra_b, r_en_b, r_out_b, hi_in_b, lo_in_b, hi_out_b, lo_out_b;
  logic busy_b, done_b, illegal_b;
  logic [15:0] retired_b;
  logic [2:0]  state_b;
  logic [14:0] ctrl_b;
  assign ctrl_b = {pc_out_b, mar_in_b, inc_pc_b, ram_rd_b, read_b, mdr_in_b, mdr_out_b,
                   ir_in_b, gra_b, r_en_b, r_out_b, hi_in_b, lo_in_b, hi_out_b, lo_out_b};

  hilo_move_sequencer #(.MEM_WAIT(0), .CNT_W(2)) dut_a (
    .clk(clk), .rst(rst), .run(run_a), .opcode(opcode_a),
    .PCout(pc_out_a), .MARin(mar_in_a), .IncPC(inc_pc_a), .RAMrd(ram_rd_a),
    .Read(read_a), .MDRin(mdr_in_a), .MDRout(mdr_out_a), .IRin(ir_in_a),
    .Gra(gra_a), .R_enableIn(r_en_a), .Rout(r_out_a), .HIin(hi_in_a),
    .LOin(lo_in_a), .HIout(hi_out_a), .LOout(lo_out_a),
    .busy(busy_a), .done(done_a), .illegal(illegal_a), .retired(retired_a),
    .state_dbg(state_a)
  );

  hilo_move_sequencer #(.MEM_WAIT(2), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .run(run_b), .opcode(opcode_b),
    .PCout(pc_out_b), .MARin(mar_in_b), .IncPC(inc_pc_b), .RAMrd(ram_rd_b),
    .Read(read_b), .MDRin(mdr_in_b), .MDRout(mdr_out_b), .IRin(ir_in_b),
    .Gra(gra_b), .R_enableIn(r_en_b), .Rout(r_out_b), .HIin(hi_in_b),
    .LOin(lo_in_b), .HIout(hi_out_b), .LOout(lo_out_b),
    .busy(busy_b), .done(done_b), .illegal(illegal_b), .retired(retired_b),
    .state_dbg(state_b)
  );

  // ---------------- datapath models / monitors ----------------
  logic [31:0] hi_a = '0, lo_a = '0, r1_a = '0, rdest_a = '0;
  logic [31:0] hi_b = '0, lo_b = '0, r1_b = '0, rdest_b = '0;
  int bus_conflicts = 0;
  int hilo_both_in  = 0;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: sample enables mid-cycle, apply model updates at the edge,
  // return #1 after the edge so the bench checks settled outputs.
  task automatic tick();
    logic [14:0] ca, cb;
    @(negedge clk);
    ca = ctrl_a;
    cb = ctrl_b;
    if ($countones({ca[14], ca[8], ca[4], ca[1], ca[0]}) > 1) bus_conflicts++;
    if ($countones({cb[14], cb[8], cb[4], cb[1], cb[0]}) > 1) bus_conflicts++;
    if (ca[3] && ca[2]) hilo_both_in++;
    if (cb[3] && cb[2]) hilo_both_in++;
    @(posedge clk);
    if (ca[4] && ca[3]) hi_a = r1_a;
    if (ca[4] && ca[2]) lo_a = r1_a;
    if (ca[5] && ca[1]) rdest_a = hi_a;
    if (ca[5] && ca[0]) rdest_a = lo_a;
    if (cb[4] && cb[3]) hi_b = r1_b;
    if (cb[4] && cb[2]) lo_b = r1_b;
    if (cb[5] && cb[1]) rdest_b = hi_b;
    if (cb[5] && cb[0]) rdest_b = lo_b;
    #1;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  int ramrd_cycles;
  int done_cycle;
  logic [1:0] exp_ret [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

  initial begin
    // ---- reset state ----
    tick();
    tick();
    chk("rst_state_a", 32'(state_a), 32'(S_IDLE));
    chk("rst_ctrl_a", 32'(ctrl_a), 32'(C_NONE));
    chk("rst_flags_a", {29'd0, busy_a, done_a, illegal_a}, 32'd0);
    chk("rst_state_b", 32'(state_b), 32'(S_IDLE));
    chk("rst_ctrl_b", 32'(ctrl_b), 32'(C_NONE));
    rst = 1'b0;

    // ---- 1: reset pulse in the middle of F1 ----
    opcode_a = OPC_MFLO;
    run_a = 1'b1;
    tick();
    chk("t1_f0_ctrl", 32'(ctrl_a), 32'(C_F0));
    tick();
    chk("t1_f1_state", 32'(state_a), 32'(S_F1));
    rst = 1'b1;
    run_a = 1'b0;
    tick();
    chk("t1_rst_state", 32'(state_a), 32'(S_IDLE));
    chk("t1_rst_ctrl", 32'(ctrl_a), 32'(C_NONE));
    chk("t1_rst_retired", 32'(retired_a), 32'd0);
    chk("t1_rst_busy", 32'(busy_a), 32'd0);
    rst = 1'b0;

    // ---- 2: single mflo, LO=15 -> Rdest ----
    lo_a = 32'd15;
    opcode_a = OPC_MFLO;
    run_a = 1'b1;
    tick();
    chk("t2_f0_busy", 32'(busy_a), 32'd1);
    run_a = 1'b0;
    tick();
    chk("t2_f1_ctrl", 32'(ctrl_a), 32'(C_F1));
    tick();
    chk("t2_f2_ctrl", 32'(ctrl_a), 32'(C_F2));
    tick();
    chk("t2_exec_ctrl", 32'(ctrl_a), 32'(C_MFLO));
    chk("t2_exec_done", 32'(done_a), 32'd1);
    chk("t2_exec_retired", 32'(retired_a), 32'd0);
    tick();
    chk("t2_idle_state", 32'(state_a), 32'(S_IDLE));
    chk("t2_done_pulse", 32'(done_a), 32'd0);
    chk("t2_rdest", rdest_a, 32'd15);
    chk("t2_retired", 32'(retired_a), 32'd1);

    // ---- 3: MEM_WAIT=2 mfhi, HI=DEADBEEF ----
    hi_b = 32'hDEADBEEF;
    opcode_b = OPC_MFHI;
    run_b = 1'b1;
    ramrd_cycles = 0;
    done_cycle = 0;
    for (int i = 1; i <= 7; i++) begin
      tick();
      if (i == 1) run_b = 1'b0;
      if (i == 2) chk("t3_wait_ctrl", 32'(ctrl_b), 32'(C_WAIT));
      if (ram_rd_b) ramrd_cycles++;
      if (done_b) done_cycle = i;
    end
    chk("t3_ramrd_cycles", 32'(ramrd_cycles), 32'd4);
    chk("t3_done_cycle", 32'(done_cycle), 32'd6);
    chk("t3_rdest", rdest_b, 32'hDEADBEEF);
    chk("t3_retired", 32'(retired_b), 32'd1);
    chk("t3_idle", 32'(state_b), 32'(S_IDLE));

    // ---- 4: back-to-back mthi then mtlo from R1=8 ----
    pulse_rst();
    r1_a = 32'd8;
    hi_a = '0;
    lo_a = '0;
    opcode_a = OPC_MTHI;
    run_a = 1'b1;
    tick(); tick(); tick(); tick();
    chk("t4_exec1_ctrl", 32'(ctrl_a), 32'(C_MTHI));
    tick();
    chk("t4_b2b_f0", 32'(state_a), 32'(S_F0));
    opcode_a = OPC_MTLO;
    tick(); tick(); tick();
    chk("t4_exec2_ctrl", 32'(ctrl_a), 32'(C_MTLO));
    run_a = 1'b0;
    tick();
    chk("t4_hi", hi_a, 32'd8);
    chk("t4_lo", lo_a, 32'd8);
    chk("t4_retired", 32'(retired_a), 32'd2);
    chk("t4_idle", 32'(state_a), 32'(S_IDLE));

    // ---- 5: illegal opcode traps ----
    opcode_a = 5'b00000;
    run_a = 1'b1;
    tick(); tick(); tick(); tick();
    chk("t5_exec_ctrl", 32'(ctrl_a), 32'(C_NONE));
    chk("t5_exec_done", 32'(done_a), 32'd0);
    tick();
    chk("t5_fault_state", 32'(state_a), 32'(S_FAULT));
    chk("t5_illegal", 32'(illegal_a), 32'd1);
    chk("t5_busy", 32'(busy_a), 32'd0);
    chk("t5_retired", 32'(retired_a), 32'd2);
    tick(); tick();
    chk("t5_stuck_state", 32'(state_a), 32'(S_FAULT));
    chk("t5_stuck_ctrl", 32'(ctrl_a), 32'(C_NONE));
    run_a = 1'b0;
    pulse_rst();
    chk("t5_rst_state", 32'(state_a), 32'(S_IDLE));
    chk("t5_rst_illegal", 32'(illegal_a), 32'd0);

    // ---- 6: CNT_W=2 wrap over 5 back-to-back mflo ----
    opcode_a = OPC_MFLO;
    run_a = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) begin
      tick();
      tick();
      if (k == 4) run_a = 1'b0;
      tick();
      chk("t6_exec_done", 32'(done_a), 32'd1);
      tick();
      chk("t6_retired", 32'(retired_a), 32'(exp_ret[k]));
      if (k < 4) chk("t6_b2b_f0", 32'(state_a), 32'(S_F0));
    end
    chk("t6_final_idle", 32'(state_a), 32'(S_IDLE));
    chk("t6_final_busy", 32'(busy_a), 32'd0);

    // ---- global invariants ----
    chk("bus_conflicts", 32'(bus_conflicts), 32'd0);
    chk("hilo_both_in", 32'(hilo_both_in), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
